// File: rtl/frame_bbox_detect.sv
// frame_bbox_detect
//   Streams a binary image and reports, once per frame, the bounding box of
//   all foreground pixels together with their count.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   per_frame_vsync/href/clken  input frame, line and pixel strobes
//   per_img_bit                 binary pixel, 1 = foreground
//   post_*                      the four inputs delayed by one clock
//   x_min/x_max/y_min/y_max     bounding box of the last completed frame
//   pix_cnt                     foreground count of the last completed frame
//   bbox_valid                  pix_cnt >= MIN_PIX for that frame
//   frame_done                  one-cycle pulse when the results update
module frame_bbox_detect #(
  parameter int IMG_W   = 1024,
  parameter int IMG_H   = 720,
  parameter int CW      = 12,
  parameter int PW      = 20,
  parameter int MIN_PIX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          per_frame_vsync,
  input  logic          per_frame_href,
  input  logic          per_frame_clken,
  input  logic          per_img_bit,
  output logic          post_frame_vsync,
  output logic          post_frame_href,
  output logic          post_frame_clken,
  output logic          post_img_bit,
  output logic [CW-1:0] x_min,
  output logic [CW-1:0] x_max,
  output logic [CW-1:0] y_min,
  output logic [CW-1:0] y_max,
  output logic [PW-1:0] pix_cnt,
  output logic          bbox_valid,
  output logic          frame_done
);

  localparam logic [CW-1:0] X_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0] X_END  = CW'(IMG_W);
  localparam logic [CW-1:0] Y_END  = CW'(IMG_H);
  localparam logic [PW:0]   MIN_V  = (PW + 1)'(MIN_PIX);

  logic          r_vsync_d;
  logic          r_href_d;
  logic [CW-1:0] r_x_cnt;
  logic [CW-1:0] r_y_cnt;
  logic [CW-1:0] r_acc_xmin;
  logic [CW-1:0] r_acc_xmax;
  logic [CW-1:0] r_acc_ymin;
  logic [CW-1:0] r_acc_ymax;
  logic [PW-1:0] r_acc_cnt;

  logic          w_accept;
  logic          w_x_in;
  logic          w_y_in;
  logic          w_fg;
  logic          w_start;
  logic          w_end;
  logic          w_href_fall;
  logic [CW-1:0] w_base_xmin;
  logic [CW-1:0] w_base_xmax;
  logic [CW-1:0] w_base_ymin;
  logic [CW-1:0] w_base_ymax;
  logic [PW-1:0] w_base_cnt;
  logic [CW-1:0] w_nxt_xmin;
  logic [CW-1:0] w_nxt_xmax;
  logic [CW-1:0] w_nxt_ymin;
  logic [CW-1:0] w_nxt_ymax;
  logic [PW-1:0] w_nxt_cnt;

  assign w_accept    = per_frame_vsync & per_frame_href & per_frame_clken;
  assign w_x_in      = (r_x_cnt < X_END);
  assign w_y_in      = (r_y_cnt < Y_END);
  assign w_fg        = w_accept & per_img_bit & w_x_in & w_y_in;
  assign w_start     = per_frame_vsync & ~r_vsync_d;
  assign w_end       = r_vsync_d & ~per_frame_vsync;
  assign w_href_fall = r_href_d & ~per_frame_href;

  // A frame start re-seeds the accumulators in the same cycle, so a pixel
  // accepted on the start cycle is merged on top of the fresh values.
  always_comb begin
    w_base_xmin = w_start ? X_LAST     : r_acc_xmin;
    w_base_xmax = w_start ? '0         : r_acc_xmax;
    w_base_ymin = w_start ? Y_LAST     : r_acc_ymin;
    w_base_ymax = w_start ? '0         : r_acc_ymax;
    w_base_cnt  = w_start ? '0         : r_acc_cnt;
    w_nxt_xmin  = w_base_xmin;
    w_nxt_xmax  = w_base_xmax;
    w_nxt_ymin  = w_base_ymin;
    w_nxt_ymax  = w_base_ymax;
    w_nxt_cnt   = w_base_cnt;
    if (w_fg) begin
      if (r_x_cnt < w_base_xmin) w_nxt_xmin = r_x_cnt;
      if (r_x_cnt > w_base_xmax) w_nxt_xmax = r_x_cnt;
      if (r_y_cnt < w_base_ymin) w_nxt_ymin = r_y_cnt;
      if (r_y_cnt > w_base_ymax) w_nxt_ymax = r_y_cnt;
      if (w_base_cnt != '1)      w_nxt_cnt  = w_base_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsync_d        <= 1'b0;
      r_href_d         <= 1'b0;
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_bit     <= 1'b0;
    end else begin
      r_vsync_d        <= per_frame_vsync;
      r_href_d         <= per_frame_href;
      post_frame_vsync <= per_frame_vsync;
      post_frame_href  <= per_frame_href;
      post_frame_clken <= per_frame_clken;
      post_img_bit     <= per_img_bit;
    end
  end

  // Counters stop one past the active area so out-of-range pixels are
  // recognisable without wrapping back into the image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x_cnt <= '0;
      r_y_cnt <= '0;
    end else begin
      if (!per_frame_href)
        r_x_cnt <= '0;
      else if (w_accept && w_x_in)
        r_x_cnt <= r_x_cnt + 1'b1;

      if (!per_frame_vsync)
        r_y_cnt <= '0;
      else if (w_href_fall && w_y_in)
        r_y_cnt <= r_y_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_xmin <= X_LAST;
      r_acc_xmax <= '0;
      r_acc_ymin <= Y_LAST;
      r_acc_ymax <= '0;
      r_acc_cnt  <= '0;
    end else begin
      r_acc_xmin <= w_nxt_xmin;
      r_acc_xmax <= w_nxt_xmax;
      r_acc_ymin <= w_nxt_ymin;
      r_acc_ymax <= w_nxt_ymax;
      r_acc_cnt  <= w_nxt_cnt;
    end
  end

  // An empty frame reports an all-zero box rather than the seed values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
      pix_cnt    <= '0;
      bbox_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_end;
      if (w_end) begin
        if (r_acc_cnt == '0) begin
          x_min <= '0;
          x_max <= '0;
          y_min <= '0;
          y_max <= '0;
        end else begin
          x_min <= r_acc_xmin;
          x_max <= r_acc_xmax;
          y_min <= r_acc_ymin;
          y_max <= r_acc_ymax;
        end
        pix_cnt    <= r_acc_cnt;
        bbox_valid <= ({1'b0, r_acc_cnt} >= MIN_V);
      end
    end
  end

endmodule
